// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary conversion used by the Gray input decoder.
package gray_pkg;

  localparam int unsigned GRAY_MAX = 32;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Zero-extended callers get the correct result for any width up to GRAY_MAX,
  // since the XOR of leading zeros leaves the lower bits untouched.
  function automatic logic [GRAY_MAX-1:0] gray2bin(input logic [GRAY_MAX-1:0] g);
    logic [GRAY_MAX-1:0] b;
    b[GRAY_MAX-1] = g[GRAY_MAX-1];
    for (int i = GRAY_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a saturating stability counter.
// accept fires while a candidate has been stable for the full window and the top says it is new.
module sync_filter
  import gray_pkg::*;
#(
  parameter int unsigned BITS      = 5,
  parameter int unsigned FILT_LOG2 = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [BITS-1:0] gray_in,
  input  logic            new_ok,
  output logic [BITS-1:0] cand,
  output logic            accept
);

  localparam logic [FILT_LOG2-1:0] CNT_MAX = '1;

  logic [BITS-1:0]      sync1;
  logic [BITS-1:0]      sync2;
  logic [FILT_LOG2-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign accept = (sync2 == cand) && (cnt == CNT_MAX) && new_ok;

endmodule

// File: rtl/gray_decoder.sv
// Gray input decoder: filtered Gray bus to binary, step classification, position and error flags.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int unsigned BITS      = 5,
  parameter int unsigned FILT_LOG2 = 2,
  parameter int unsigned POS_BITS  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [BITS-1:0]     gray_in,
  input  logic                err_clr,
  output logic [BITS-1:0]     bin_out,
  output logic                step_up,
  output logic                step_dn,
  output logic                step_err,
  output logic                err_sticky,
  output logic                primed,
  output logic [POS_BITS-1:0] position
);

  state_t              state, state_nxt;
  logic [BITS-1:0]     cand;
  logic                accept;
  logic                new_ok;
  logic [BITS-1:0]     cand_bin;
  logic [BITS-1:0]     delta;
  logic [BITS-1:0]     bin_nxt;
  logic [POS_BITS-1:0] pos_nxt;
  logic                err_nxt, primed_nxt, up_nxt, dn_nxt, er_nxt;

  sync_filter #(
    .BITS      (BITS),
    .FILT_LOG2 (FILT_LOG2)
  ) u_sync_filter (
    .clk     (clk),
    .resetn  (resetn),
    .gray_in (gray_in),
    .new_ok  (new_ok),
    .cand    (cand),
    .accept  (accept)
  );

  assign cand_bin = BITS'(gray2bin(GRAY_MAX'(cand)));
  assign delta    = cand_bin - bin_out;
  // The first value after reset is accepted even when it equals the reset value of bin_out.
  assign new_ok   = (state == INIT) || (cand_bin != bin_out);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bin_nxt    = bin_out;
    pos_nxt    = position;
    err_nxt    = err_sticky & ~err_clr;
    primed_nxt = primed;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    er_nxt     = 1'b0;
    if (accept) begin
      bin_nxt = cand_bin;
      case (state)
        INIT: begin
          state_nxt  = TRACK;
          primed_nxt = 1'b1;
        end
        TRACK: begin
          if (delta == BITS'(1)) begin
            up_nxt  = 1'b1;
            pos_nxt = position + POS_BITS'(1);
          end else if (delta == {BITS{1'b1}}) begin
            dn_nxt  = 1'b1;
            pos_nxt = position - POS_BITS'(1);
          end else begin
            er_nxt  = 1'b1;
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_out    <= '0;
      position   <= '0;
      err_sticky <= 1'b0;
      primed     <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      bin_out    <= bin_nxt;
      position   <= pos_nxt;
      err_sticky <= err_nxt;
      primed     <= primed_nxt;
      step_up    <= up_nxt;
      step_dn    <= dn_nxt;
      step_err   <= er_nxt;
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: directed Gray vectors, expected events queued, monitor compares.
module tb_gray_decoder;

  localparam int K_INIT = 0;
  localparam int K_UP   = 1;
  localparam int K_DN   = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [4:0]  bin;
    logic [15:0] pos;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  gray_in = '0;
  logic        err_clr = 1'b0;
  logic [4:0]  bin_out;
  logic        step_up, step_dn, step_err, err_sticky, primed;
  logic [15:0] position;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic primed_d = 1'b0;

  gray_decoder #(
    .BITS      (5),
    .FILT_LOG2 (2),
    .POS_BITS  (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .primed     (primed),
    .position   (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any pulse or rising primed is a DUT event; compare with the head of the queue.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    logic ev;
    ev = step_up | step_dn | step_err | (primed & ~primed_d);
    if (ev) begin
      check("one_hot_pulse", int'(step_up) + int'(step_dn) + int'(step_err) <= 1, 1);
      if (step_up) kind = K_UP;
      else if (step_dn) kind = K_DN;
      else if (step_err) kind = K_ERR;
      else kind = K_INIT;
      if (exp_q.size() == 0) begin
        check("unexpected_event_kind", kind, -1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_bin", int'(bin_out), int'(e.bin));
        check("event_pos", int'(position), int'(e.pos));
        check("event_err", int'(err_sticky), int'(e.err));
        check("event_primed", int'(primed), 1);
      end
    end
    primed_d = primed;
  end

  task automatic apply(input logic [4:0] g, input int kind, input logic [4:0] b,
                       input logic [15:0] p, input logic e);
    exp_t x;
    x.kind = kind; x.bin = b; x.pos = p; x.err = e;
    exp_q.push_back(x);
    @(negedge clk);
    gray_in = g;
    repeat (10) @(negedge clk);
    check("event_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bin"}, int'(bin_out), 0);
    check({tag, "_pos"}, int'(position), 0);
    check({tag, "_pulses"}, int'({step_up, step_dn, step_err}), 0);
    check({tag, "_err"}, int'(err_sticky), 0);
    check({tag, "_primed"}, int'(primed), 0);
  endtask

  initial begin
    exp_t x;
    logic [4:0] k5;
    // Reset held: everything at zero.
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // First value after reset (0) is accepted silently.
    x.kind = K_INIT; x.bin = 5'd0; x.pos = 16'd0; x.err = 1'b0;
    exp_q.push_back(x);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    check("prime_drained", exp_q.size(), 0);
    check("primed_high", int'(primed), 1);

    // Up steps 0 -> 1 -> 2 -> 3.
    apply(5'b00001, K_UP, 5'd1, 16'd1, 1'b0);
    apply(5'b00011, K_UP, 5'd2, 16'd2, 1'b0);
    apply(5'b00010, K_UP, 5'd3, 16'd3, 1'b0);
    // Down steps back to 0, then wrap 0 -> 31.
    apply(5'b00011, K_DN, 5'd2, 16'd2, 1'b0);
    apply(5'b00001, K_DN, 5'd1, 16'd1, 1'b0);
    apply(5'b00000, K_DN, 5'd0, 16'd0, 1'b0);
    apply(5'b10000, K_DN, 5'd31, 16'hFFFF, 1'b0);
    // Wrap 31 -> 0 is an up step; position wraps back to 0.
    apply(5'b00000, K_UP, 5'd0, 16'd0, 1'b0);

    // Illegal jump 0 -> 2.
    apply(5'b00011, K_ERR, 5'd2, 16'd0, 1'b1);
    check("err_held", int'(err_sticky), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", int'(err_sticky), 0);

    // New error while err_clr is held: error wins on that edge.
    err_clr = 1'b1;
    apply(5'b00000, K_ERR, 5'd0, 16'd0, 1'b1);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared_after_hold", int'(err_sticky), 0);

    // Short glitch is filtered out.
    @(negedge clk);
    gray_in = 5'b00001;
    repeat (4) @(negedge clk);
    gray_in = 5'b00000;
    repeat (15) @(negedge clk);
    check("glitch_bin", int'(bin_out), 0);
    check("glitch_pos", int'(position), 0);

    // Full revolution of up steps.
    for (int k = 1; k <= 32; k++) begin
      k5 = 5'(k);
      apply(k5 ^ (k5 >> 1), K_UP, k5, 16'(k), 1'b0);
    end
    check("rev_bin", int'(bin_out), 0);
    check("rev_pos", int'(position), 32);

    // Asynchronous reset in the middle of a filter window.
    @(negedge clk);
    gray_in = 5'b00001;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (12) @(negedge clk);
    check_all_zero("reset_hold");
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
